sa_pg_seq: RTL and testbench
============================

Name: sa_pg_seq

Overview:
- Power-gating sequencer for one switchable SA partition.
- Drives the isolation clamp nets. These are the A2 inputs of the partition's 2-input AND isolation cells, so a 0 clamps every output to 0.
- Also drives the partition clock enable, the retention save/restore strobes and the power-switch chain sleep control.
- Sits in the always-on domain and takes a single level request from the SA power manager.

Parameters:
- ISO_DLY, 4: cycles spent in each clamp/clock settle state (min 1).
- RET_DLY, 2: cycles each retention strobe is held high (min 1).
- SW_TIMEOUT, 200: max cycles to wait for the switch-chain acknowledge (min 1).
- CNT_W, 8: state-timer width; must satisfy 2^CNT_W > max(ISO_DLY, RET_DLY, SW_TIMEOUT).

Ports:
- nvdla_core_clk, input, 1: always-on clock.
- nvdla_core_rst, input, 1: reset, asynchronous, active-high.
- pwr_on_req, input, 1: level request; 1 = partition powered, 0 = partition off.
- sw_ack, input, 1: switch-chain acknowledge, asynchronous; 1 = rail up. Passes through a 2-flop synchronizer before use.
- iso_clamp_n, output, 1: isolation enable to the AND isolation cells; 0 = clamp.
- clk_en, output, 1: partition clock-gate enable.
- sw_sleep, output, 1: power-switch chain control; 1 = switches open (rail off).
- ret_save, output, 1: retention save strobe.
- ret_restore, output, 1: retention restore strobe.
- pwr_on_status, output, 1: 1 only in state ON.
- busy, output, 1: 1 in every state except ON and OFF.
- timeout_err, output, 1: sticky acknowledge-timeout flag.

Behaviour:
- All outputs are registered. Each output's value is a function of the state being entered and changes on the same edge as the state change.
- Values in reset and in OFF: iso_clamp_n=0, clk_en=0, sw_sleep=1, ret_save=0, ret_restore=0, pwr_on_status=0, busy=0, timeout_err=0, synchronizer flops=0, state=OFF.
- Asserting reset mid-sequence forces this safe state immediately; no partial sequence resumes.
- A state timer loads on each state entry. A timed state lasts exactly its parameter count in cycles.
- States and transitions:
  - OFF: pwr_on_req=1 -> SW_ON.
  - SW_ON: sw_sleep=0. ack_s=1 -> RESTORE. SW_TIMEOUT cycles without ack -> set timeout_err, sw_sleep=1, go to OFF.
  - RESTORE: ret_restore=1 for RET_DLY cycles -> CLK_ON. ret_restore drops on exit.
  - CLK_ON: clk_en=1; wait ISO_DLY cycles -> UNCLAMP.
  - UNCLAMP: iso_clamp_n=1 for 1 cycle -> ON.
  - ON: pwr_on_status=1. pwr_on_req=0 -> CLAMP. pwr_on_status drops on the edge that enters CLAMP.
  - CLAMP: iso_clamp_n=0; wait ISO_DLY cycles -> CLK_OFF.
  - CLK_OFF: clk_en=0; wait ISO_DLY cycles -> SAVE.
  - SAVE: ret_save=1 for RET_DLY cycles -> SW_OFF.
  - SW_OFF: sw_sleep=1. ack_s=0 -> OFF. SW_TIMEOUT cycles without the ack dropping -> set timeout_err, go to OFF anyway.
- Sequence invariants, which must hold in every cycle:
  - iso_clamp_n=1 implies clk_en=1 and sw_sleep=0.
  - ret_save=1 implies iso_clamp_n=0 and clk_en=0.
  - ret_save and ret_restore are never both 1.
- Request changes during busy are not aborts. The sequence in progress completes, then pwr_on_req is re-sampled in ON/OFF. A request toggle shorter than a full sequence therefore produces a full down/up cycle, or no action if it reverts before ON/OFF is reached.
- timeout_err clears on the edge entering SW_ON or CLAMP; a new request clears it.
- ack_s is sync flop 2. An sw_ack change is visible to the state machine 2 cycles later, so the minimum SW_ON dwell is 2 cycles.
- Timer arithmetic:
  - Unsigned down-count; the exit condition is timer==0, not underflow.
  - CNT_W too small for the parameters is an elaboration error.

Test Plan:
- Reset, then pwr_on_req=1 with sw_ack tied to ~sw_sleep, defaults -> order is sw_sleep falls, ret_restore high 2 cycles, clk_en rises, 4 cycles later iso_clamp_n rises, pwr_on_status=1. Total 2+2+4+1 cycles from SW_ON entry to ON.
- From ON, pwr_on_req=0 -> iso_clamp_n=0, 4 cycles later clk_en=0, 4 cycles later ret_save high 2 cycles, then sw_sleep=1. OFF is reached 2 cycles after sw_sleep rises; pwr_on_status=0 from the first edge.
- sw_ack held 0 after the up request -> after 200 cycles in SW_ON: timeout_err=1, sw_sleep=1, state OFF, iso_clamp_n stays 0 throughout. A new request clears timeout_err.
- pwr_on_req pulsed 1 for 1 cycle while in OFF -> full power-up to ON, then immediate full power-down to OFF. Invariants are checked every cycle.
- Reset asserted mid-CLK_ON -> same cycle: clk_en=0, iso_clamp_n=0, sw_sleep=1, busy=0, no ret_save pulse.
- sw_ack glitch 1-cycle high in SW_OFF with ISO_DLY=1, RET_DLY=1 -> no premature transition back. OFF is entered only after sw_ack is stably 0 for 2 cycles.

Source files
------------

// File: rtl/sa_pg_seq_if.sv
// Handshake bundle between the SA power manager and the
// power-gating sequencer of one switchable partition.
interface sa_pg_seq_if;
    logic pwr_on_req;
    logic sw_ack;
    logic iso_clamp_n;
    logic clk_en;
    logic sw_sleep;
    logic ret_save;
    logic ret_restore;
    logic pwr_on_status;
    logic busy;
    logic timeout_err;

    modport master (
        output pwr_on_req, sw_ack,
        input  iso_clamp_n, clk_en, sw_sleep, ret_save,
        input  ret_restore, pwr_on_status, busy, timeout_err
    );

    modport slave (
        input  pwr_on_req, sw_ack,
        output iso_clamp_n, clk_en, sw_sleep, ret_save,
        output ret_restore, pwr_on_status, busy, timeout_err
    );
endinterface

// File: rtl/sa_pg_seq.sv
// Power-gating sequencer for one switchable SA partition.
// Always-on domain; every output is registered from the state being entered.
module sa_pg_seq #(
    parameter int ISO_DLY    = 4,
    parameter int RET_DLY    = 2,
    parameter int SW_TIMEOUT = 200,
    parameter int CNT_W      = 8
) (
    input logic        nvdla_core_clk,
    input logic        nvdla_core_rst,
    sa_pg_seq_if.slave pg
);
    localparam int MAX_A = (ISO_DLY > RET_DLY) ? ISO_DLY : RET_DLY;
    localparam int MAX_D = (MAX_A > SW_TIMEOUT) ? MAX_A : SW_TIMEOUT;

    if (ISO_DLY < 1 || RET_DLY < 1 || SW_TIMEOUT < 1 || CNT_W < 1 ||
        (64'd1 << CNT_W) <= 64'(MAX_D)) begin : g_param_err
        $error("sa_pg_seq: bad delay parameters or CNT_W too small");
    end

    localparam logic [CNT_W-1:0] T_ISO = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] T_RET = CNT_W'(RET_DLY - 1);
    localparam logic [CNT_W-1:0] T_SW  = CNT_W'(SW_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_OFF, S_SW_ON, S_RESTORE, S_CLK_ON, S_UNCLAMP,
        S_ON, S_CLAMP, S_CLK_OFF, S_SAVE, S_SW_OFF
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             ack_meta, ack_s;
    logic             tmo, enter, t_zero;
    logic             iso_q, clk_q, sleep_q, save_q, rest_q;
    logic             stat_q, busy_q, terr_q;
    logic             iso_n, clk_n, sleep_n, save_n, rest_n;
    logic             stat_n, busy_n, terr_n;

    // First stage samples on the falling edge, so an ack change is seen
    // by the state machine on the second rising edge after it moves.
    always_ff @(negedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) ack_meta <= 1'b0;
        else                ack_meta <= pg.sw_ack;
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            ack_s   <= 1'b0;
            state   <= S_OFF;
            timer   <= '0;
            iso_q   <= 1'b0;
            clk_q   <= 1'b0;
            sleep_q <= 1'b1;
            save_q  <= 1'b0;
            rest_q  <= 1'b0;
            stat_q  <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            ack_s   <= ack_meta;
            state   <= state_nxt;
            timer   <= timer_nxt;
            iso_q   <= iso_n;
            clk_q   <= clk_n;
            sleep_q <= sleep_n;
            save_q  <= save_n;
            rest_q  <= rest_n;
            stat_q  <= stat_n;
            busy_q  <= busy_n;
            terr_q  <= terr_n;
        end
    end

    assign t_zero = (timer == '0);

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        unique case (state)
            S_OFF:     if (pg.pwr_on_req) state_nxt = S_SW_ON;
            S_SW_ON: begin
                if (ack_s) state_nxt = S_RESTORE;
                else if (t_zero) begin
                    state_nxt = S_OFF;
                    tmo       = 1'b1;
                end
            end
            S_RESTORE: if (t_zero) state_nxt = S_CLK_ON;
            S_CLK_ON:  if (t_zero) state_nxt = S_UNCLAMP;
            S_UNCLAMP: state_nxt = S_ON;
            S_ON:      if (!pg.pwr_on_req) state_nxt = S_CLAMP;
            S_CLAMP:   if (t_zero) state_nxt = S_CLK_OFF;
            S_CLK_OFF: if (t_zero) state_nxt = S_SAVE;
            S_SAVE:    if (t_zero) state_nxt = S_SW_OFF;
            S_SW_OFF: begin
                if (!ack_s) state_nxt = S_OFF;
                else if (t_zero) begin
                    state_nxt = S_OFF;
                    tmo       = 1'b1;
                end
            end
            default:   state_nxt = S_OFF;
        endcase
    end

    assign enter = (state_nxt != state);

    always_comb begin
        iso_n   = 1'b0;
        clk_n   = 1'b0;
        sleep_n = 1'b0;
        save_n  = 1'b0;
        rest_n  = 1'b0;
        stat_n  = 1'b0;
        busy_n  = 1'b1;
        unique case (state_nxt)
            S_OFF:     begin sleep_n = 1'b1; busy_n = 1'b0; end
            S_SW_ON:   begin end
            S_RESTORE: rest_n = 1'b1;
            S_CLK_ON:  clk_n  = 1'b1;
            S_UNCLAMP: begin clk_n = 1'b1; iso_n = 1'b1; end
            S_ON: begin
                clk_n  = 1'b1;
                iso_n  = 1'b1;
                stat_n = 1'b1;
                busy_n = 1'b0;
            end
            S_CLAMP:   clk_n  = 1'b1;
            S_CLK_OFF: begin end
            S_SAVE:    save_n = 1'b1;
            S_SW_OFF:  sleep_n = 1'b1;
            default:   begin sleep_n = 1'b1; busy_n = 1'b0; end
        endcase

        terr_n = terr_q | tmo;
        if (enter && (state_nxt == S_SW_ON || state_nxt == S_CLAMP))
            terr_n = 1'b0;

        // Timer reloads on every state entry and counts down to zero.
        timer_nxt = t_zero ? timer : timer - CNT_W'(1);
        if (enter) begin
            unique case (state_nxt)
                S_SW_ON, S_SW_OFF:           timer_nxt = T_SW;
                S_RESTORE, S_SAVE:           timer_nxt = T_RET;
                S_CLK_ON, S_CLAMP, S_CLK_OFF: timer_nxt = T_ISO;
                default:                     timer_nxt = '0;
            endcase
        end
    end

    assign pg.iso_clamp_n   = iso_q;
    assign pg.clk_en        = clk_q;
    assign pg.sw_sleep      = sleep_q;
    assign pg.ret_save      = save_q;
    assign pg.ret_restore   = rest_q;
    assign pg.pwr_on_status = stat_q;
    assign pg.busy          = busy_q;
    assign pg.timeout_err   = terr_q;
endmodule

// File: tb/tb_sa_pg_seq.sv
// Bench for sa_pg_seq: two instances (default and ISO/RET=1) against a
// phase/offset model, with directed sequence timing checks.
module tb_sa_pg_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req;
    logic       frc_en, frc_val, glitch;
    logic [7:0] o0, o1;
    logic [1:0] ack;
    int         n_cmp = 0;
    int         n_bad = 0;

    sa_pg_seq_if bus0 ();
    sa_pg_seq_if bus1 ();

    assign bus0.pwr_on_req = req[0];
    assign bus1.pwr_on_req = req[1];
    assign bus0.sw_ack = frc_en ? frc_val : ~bus0.sw_sleep;
    assign bus1.sw_ack = glitch | ~bus1.sw_sleep;
    assign ack = {bus1.sw_ack, bus0.sw_ack};

    assign o0 = {bus0.iso_clamp_n, bus0.clk_en, bus0.sw_sleep, bus0.ret_save,
                 bus0.ret_restore, bus0.pwr_on_status, bus0.busy, bus0.timeout_err};
    assign o1 = {bus1.iso_clamp_n, bus1.clk_en, bus1.sw_sleep, bus1.ret_save,
                 bus1.ret_restore, bus1.pwr_on_status, bus1.busy, bus1.timeout_err};

    sa_pg_seq u0 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .pg             (bus0.slave)
    );

    sa_pg_seq #(.ISO_DLY(1), .RET_DLY(1)) u1 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .pg             (bus1.slave)
    );

    localparam int B_ISO = 7, B_CLK = 6, B_SLP = 5, B_SAVE = 4;
    localparam int B_REST = 3, B_ST = 2, B_BUSY = 1, B_TERR = 0;
    localparam int M_OFF = 0, M_UPACK = 1, M_UP = 2;
    localparam int M_ON = 3, M_DN = 4, M_DNACK = 5;

    int   iso_p [2] = '{4, 1};
    int   ret_p [2] = '{2, 1};
    int   to_p  [2] = '{200, 200};
    int   mode  [2];
    int   k     [2];
    logic terr  [2];
    logic samp  [2];

    // Expected outputs from phase and offset inside the fixed sequences.
    function automatic logic [7:0] model_out(int i);
        logic iso, ce, slp, sv, rs, st, bz;
        iso = 0; ce = 0; slp = 0; sv = 0; rs = 0; st = 0; bz = 1;
        case (mode[i])
            M_OFF: begin slp = 1; bz = 0; end
            M_UP: begin
                rs  = k[i] < ret_p[i];
                ce  = k[i] >= ret_p[i];
                iso = k[i] == ret_p[i] + iso_p[i];
            end
            M_ON: begin ce = 1; iso = 1; st = 1; bz = 0; end
            M_DN: begin
                ce = k[i] < iso_p[i];
                sv = k[i] >= 2 * iso_p[i];
            end
            M_DNACK: slp = 1;
            default: ;
        endcase
        return {iso, ce, slp, sv, rs, st, bz, terr[i]};
    endfunction

    task automatic step(int i, logic r, logic a);
        case (mode[i])
            M_OFF: if (r) begin mode[i] = M_UPACK; k[i] = 0; terr[i] = 0; end
            M_UPACK: begin
                if (a) begin mode[i] = M_UP; k[i] = 0; end
                else if (k[i] == to_p[i] - 1) begin mode[i] = M_OFF; terr[i] = 1; end
                else k[i]++;
            end
            M_UP: if (k[i] == ret_p[i] + iso_p[i]) mode[i] = M_ON; else k[i]++;
            M_ON: if (!r) begin mode[i] = M_DN; k[i] = 0; terr[i] = 0; end
            M_DN: begin
                if (k[i] == 2 * iso_p[i] + ret_p[i] - 1) begin mode[i] = M_DNACK; k[i] = 0; end
                else k[i]++;
            end
            M_DNACK: begin
                if (!a) mode[i] = M_OFF;
                else if (k[i] == to_p[i] - 1) begin mode[i] = M_OFF; terr[i] = 1; end
                else k[i]++;
            end
            default: mode[i] = M_OFF;
        endcase
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] act, exp_v;
            logic       inv;
            if (rst) begin
                mode[i] = M_OFF; k[i] = 0; terr[i] = 0; samp[i] = 0;
            end
            act   = (i == 0) ? o0 : o1;
            exp_v = model_out(i);
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                $display("FAIL u%0d outputs t=%0t got %b expected %b", i, $time, act, exp_v);
            end
            inv = (!act[B_ISO] || (act[B_CLK] && !act[B_SLP])) &&
                  (!act[B_SAVE] || (!act[B_ISO] && !act[B_CLK])) &&
                  !(act[B_SAVE] && act[B_REST]);
            n_cmp++;
            if (inv !== 1'b1) begin
                n_bad++;
                $display("FAIL u%0d invariant t=%0t got %b expected 1", i, $time, inv);
            end
            if (!rst) begin
                step(i, req[i], samp[i]);
                samp[i] = ack[i];
            end
        end
    end

    logic [7:0] hist [0:255];

    task automatic chk(string name, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic record(int ui, int n);
        for (int j = 1; j <= n; j++) begin
            @(posedge clk); #1;
            hist[j] = (ui == 0) ? o0 : o1;
        end
    endtask

    function automatic int first_at(int b, logic v, int from, int to);
        for (int j = from; j <= to; j++)
            if (hist[j][b] == v) return j;
        return -1;
    endfunction

    function automatic int ones(int b, int from, int to);
        int c = 0;
        for (int j = from; j <= to; j++) c += int'(hist[j][b]);
        return c;
    endfunction

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        req = 2'b00; frc_en = 0; frc_val = 0; glitch = 0;
        for (int i = 0; i < 2; i++) begin
            mode[i] = M_OFF; k[i] = 0; terr[i] = 0; samp[i] = 0;
        end
        idle(3);
        chk("reset_u0", o0, 8'h20);
        chk("reset_u1", o1, 8'h20);
        rst = 0;
        idle(2);

        // power-up order and timing
        req[0] = 1;
        record(0, 14);
        chk("up_sleep_fall", first_at(B_SLP, 0, 1, 14), 1);
        chk("up_restore_rise", first_at(B_REST, 1, 1, 14), 3);
        chk("up_restore_len", ones(B_REST, 1, 14), 2);
        chk("up_clk_rise", first_at(B_CLK, 1, 1, 14), 5);
        chk("up_iso_rise", first_at(B_ISO, 1, 1, 14), 9);
        chk("up_status", first_at(B_ST, 1, 1, 14), 10);

        // power-down order and timing
        req[0] = 0;
        record(0, 16);
        chk("dn_iso_fall", first_at(B_ISO, 0, 1, 16), 1);
        chk("dn_status_fall", first_at(B_ST, 0, 1, 16), 1);
        chk("dn_clk_fall", first_at(B_CLK, 0, 1, 16), 5);
        chk("dn_save_rise", first_at(B_SAVE, 1, 1, 16), 9);
        chk("dn_save_len", ones(B_SAVE, 1, 16), 2);
        chk("dn_sleep_rise", first_at(B_SLP, 1, 1, 16), 11);
        chk("dn_off", first_at(B_BUSY, 0, 1, 16), 13);

        // ack never arrives
        frc_en = 1; frc_val = 0; req[0] = 1;
        record(0, 205);
        chk("tmo_set", first_at(B_TERR, 1, 1, 205), 201);
        chk("tmo_sleep", int'(hist[201][B_SLP]), 1);
        chk("tmo_off", int'(hist[201][B_BUSY]), 0);
        chk("tmo_no_unclamp", first_at(B_ISO, 1, 1, 201), -1);
        chk("tmo_clear", first_at(B_TERR, 0, 202, 205), 202);
        frc_en = 0;
        idle(30);
        req[0] = 0;
        idle(40);

        // one-cycle request pulse
        req[0] = 1;
        @(posedge clk); #1;
        req[0] = 0;
        record(0, 40);
        chk("pulse_on", first_at(B_ST, 1, 1, 40), 9);
        chk("pulse_leave_on", first_at(B_ST, 0, 10, 40), 10);
        chk("pulse_off", first_at(B_BUSY, 0, 10, 40), 22);

        // reset in the middle of CLK_ON
        req[0] = 1;
        record(0, 6);
        chk("pre_rst_clk", int'(hist[6][B_CLK]), 1);
        rst = 1;
        #1;
        chk("rst_mid_clk_on", o0, 8'h20);
        req[0] = 0;
        idle(2);
        rst = 0;
        record(0, 20);
        chk("rst_no_save", first_at(B_SAVE, 1, 1, 20), -1);
        chk("rst_stay_off", first_at(B_BUSY, 1, 1, 20), -1);

        // ack glitch while switching off, short delays
        req[1] = 1;
        idle(20);
        req[1] = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #1;
            hist[j] = o1;
            glitch = (j == 4);
        end
        glitch = 0;
        chk("gl_sw_off", int'(hist[4][B_SLP]), 1);
        chk("gl_off_edge", first_at(B_BUSY, 0, 1, 12), 7);
        chk("gl_no_reopen", first_at(B_SLP, 0, 5, 12), -1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(39) == 0) req[0] = ~req[0];
            if ($urandom_range(29) == 0) req[1] = ~req[1];
            if ($urandom_range(149) == 0) begin
                frc_en  = ~frc_en;
                frc_val = 1'($urandom_range(1));
            end
            glitch = ($urandom_range(49) == 0);
            if (rst) rst = 0;
            else if ($urandom_range(799) == 0) rst = 1;
        end
        rst = 0; frc_en = 0; glitch = 0;
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
